// File: rtl/spi_frame_transmitter_if.sv
// Sample-input handshake bundle for spi_frame_transmitter.
// The master is the sample source and the slave is the transmitter.
interface spi_frame_transmitter_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/spi_frame_transmitter.sv
// SPI master serializer: FIFO-buffered samples, one chip-select frame
// per sample (MSB-first data, zero padding), then an inter-frame gap.
module spi_frame_transmitter #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_BITS = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                          serial_clk,
    input  logic                          reset,
    spi_frame_transmitter_if.slave        in_if,
    output logic                          chip_select,
    output logic                          mosi,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FRAME_BITS);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [FW-1:0] LAST_DATA  = FW'(DATA_WIDTH - 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(FRAME_BITS - 1);
    localparam logic [GW-1:0] LAST_GAP   = GW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PAD,
        GAP
    } state_t;

    state_t                state_q;
    logic                  cs_q;
    logic                  mosi_q;
    logic                  done_q;
    logic [FW-1:0]         fcnt_q;
    logic [GW-1:0]         gcnt_q;
    logic [DATA_WIDTH-1:0] sh_q;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_q;
    logic [AW-1:0]         rd_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    assign in_if.in_ready = (cnt_q != FULL_CNT);
    assign push = in_if.in_valid && in_if.in_ready;
    assign head = mem_q[rd_q];

    // A frame may start from IDLE or on the last gap cycle, so
    // back-to-back frames see exactly GAP_CYCLES high cycles.
    assign pop = (cnt_q != '0) &&
                 ((state_q == IDLE) ||
                  ((state_q == GAP) && (gcnt_q == LAST_GAP)));

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge serial_clk) begin
        if (push) begin
            mem_q[wr_q] <= in_if.in_data;
        end
    end

    always_ff @(posedge serial_clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge serial_clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            fcnt_q  <= '0;
            gcnt_q  <= '0;
            sh_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (pop) begin
                state_q <= SHIFT;
                cs_q    <= 1'b0;
                mosi_q  <= head[DATA_WIDTH-1];
                sh_q    <= head;
                fcnt_q  <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        cs_q   <= 1'b1;
                        mosi_q <= 1'b0;
                    end
                    SHIFT, PAD: begin
                        fcnt_q <= fcnt_q + 1'b1;
                        if (fcnt_q == LAST_FRAME) begin
                            state_q <= GAP;
                            cs_q    <= 1'b1;
                            mosi_q  <= 1'b0;
                            done_q  <= 1'b1;
                            gcnt_q  <= '0;
                        end else if (state_q == SHIFT) begin
                            if (fcnt_q == LAST_DATA) begin
                                state_q <= PAD;
                                mosi_q  <= 1'b0;
                            end else begin
                                mosi_q <= sh_q[DATA_WIDTH-2];
                                sh_q   <= {sh_q[DATA_WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                    GAP: begin
                        if (gcnt_q == LAST_GAP) begin
                            state_q <= IDLE;
                        end else begin
                            gcnt_q <= gcnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign chip_select = cs_q;
    assign mosi        = mosi_q;
    assign frame_done  = done_q;
    assign busy        = (state_q != IDLE);
    assign fifo_count  = cnt_q;
endmodule

// File: doc/spi_frame_transmitter.md
Name: spi_frame_transmitter

Overview:
- SPI master-side serializer that sits directly upstream of the team's SPI receiver.
- Accepts 16-bit audio samples over a valid/ready handshake and buffers them in a small FIFO.
- Emits each sample as one chip-select frame on mosi: MSB first, 16 data bits, then 16 pad bits (32-cycle frame), followed by an inter-frame gap.
- The frame timing is sized so the downstream receiver captures exactly one word per frame and its 32-count wraps cleanly.

Parameters:
- DATA_WIDTH, 16, sample width in bits; also the number of data bits per frame.
- FRAME_BITS, 32, cycles chip_select is held low per frame; must be >= DATA_WIDTH.
- FIFO_DEPTH, 4, input buffer depth in words; power of two, >= 2.
- GAP_CYCLES, 1, cycles chip_select is held high between frames; >= 1.

Ports:
- reset  input  1  asynchronous, active-low reset.
- serial_clk  input  1  clock; all state updates on posedge.
- in_data  input  DATA_WIDTH  sample to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  FIFO can accept a word; equals FIFO not full.
- chip_select  output  1  active-low frame enable to the receiver; registered.
- mosi  output  1  serial data, MSB first; registered.
- busy  output  1  state != IDLE.
- frame_done  output  1  one-cycle pulse on the cycle chip_select returns high.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently buffered.

Behaviour:
- Reset (async, reset=0):
  - chip_select=1, mosi=0, busy=0, frame_done=0, fifo_count=0, in_ready=1.
  - FIFO pointers cleared; state=IDLE.
  - Reset mid-frame aborts the frame immediately (chip_select high); buffered words are discarded.
- FIFO:
  - Push when in_valid && in_ready. The source must hold in_data and in_valid while in_ready=0.
  - Pop occurs only on a frame start and requires fifo_count>0, taken from the registered count.
  - Simultaneous push and pop leaves the count unchanged.
  - A push into an empty FIFO cannot be popped in the same cycle. Minimum latency from accepted push to chip_select low is 2 cycles.
  - Full: in_ready=0. A pop in that cycle raises in_ready the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Data order is strictly FIFO.
- State machine: IDLE, SHIFT, PAD, GAP.
- IDLE:
  - chip_select=1, mosi=0.
  - If fifo_count>0: pop head into shift register, set chip_select<=0 and mosi<=word[DATA_WIDTH-1], clear bit counter, go to SHIFT.
- SHIFT:
  - Each posedge, increment bit counter; mosi <= next lower bit.
  - After bit 0 has been driven for one cycle (counter = DATA_WIDTH-1), set mosi<=0 and go to PAD.
- PAD:
  - chip_select stays 0 and mosi=0 until chip_select has been low for exactly FRAME_BITS posedges.
  - Then set chip_select<=1, pulse frame_done, and go to GAP.
- GAP:
  - chip_select=1 for GAP_CYCLES cycles total, including the frame_done cycle. Then go to IDLE.
  - IDLE may start the next frame in the same cycle it is entered if fifo_count>0.
  - Back-to-back frames are therefore separated by GAP_CYCLES+0 high cycles. No extra idle cycle is inserted.
- Timing vs receiver:
  - The receiver samples on the posedge after each mosi update.
  - It sees FRAME_BITS consecutive low-chip_select samples: bits MSB..LSB on samples 1..16, zeros on samples 17..32.
- Outputs are fully registered. No combinational path from in_valid to chip_select or mosi.
- busy=1 in SHIFT, PAD and GAP.

Test Plan:
- Reset then push 0xA5C3 once:
  - chip_select low exactly 32 cycles.
  - mosi sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, then 16 zeros.
  - frame_done pulses once.
  - Receiver data_out == 0xA5C3.
- Push 0x0001, 0x8000, 0xFFFF back-to-back with in_valid held:
  - Three frames, each separated by exactly 1 high cycle.
  - Receiver outputs 0x0001, 0x8000, 0xFFFF in order.
- Hold in_valid with 6 distinct words while the first frame is shifting:
  - in_ready drops when fifo_count=4.
  - No word is lost or duplicated; all 6 are received in order.
- Assert reset at bit 7 of a 0x1234 frame with 2 words queued:
  - chip_select=1 and mosi=0 immediately.
  - fifo_count=0; no frame_done pulse.
  - After release, a new push 0x5678 is received correctly.
- Idle bus with no input for 100 cycles:
  - chip_select stays 1, mosi stays 0, busy=0.
  - Push 0x00FF: chip_select goes low 2 cycles after the accepted push.
- GAP_CYCLES=3, two queued words: chip_select is high for exactly 3 cycles between frames.
